// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency pipeline; results are routed back by tag.
// Per-requester saturating grant counters are added when PIPE_RR_ARBITER_STATS_EN is defined.
module pipe_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LATENCY    = 10
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          en_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic [DATA_WIDTH-1:0]         pipe_data_out,
    output logic                          pipe_valid_out,
    output logic                          pipe_en_out,
    input  logic [DATA_WIDTH-1:0]         pipe_data_in,
    input  logic                          pipe_valid_in,
    output logic [DATA_WIDTH-1:0]         rsp_data_out,
    output logic [NUM_REQ-1:0]            rsp_valid_out,
`ifdef PIPE_RR_ARBITER_STATS_EN
    output logic [NUM_REQ*16-1:0]         grant_cnt_out,
`endif
    output logic                          err_out
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IdxW-1:0]                 last_grant_q, last_grant_d;
    logic [IdxW-1:0]                 cand;
    logic [IdxW-1:0]                 grant_idx;
    logic                            grant_any;
    logic                            xfer;
    logic [DATA_WIDTH-1:0]           grant_data;
    logic [DATA_WIDTH-1:0]           pipe_data_q, pipe_data_d;
    logic                            pipe_valid_q, pipe_valid_d;
    logic [IdxW-1:0]                 pipe_idx_q, pipe_idx_d;
    logic [LATENCY-1:0]              tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0][IdxW-1:0]    tag_idx_q, tag_idx_d;
    logic [DATA_WIDTH-1:0]           rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic                            err_q, err_d;

    // Search starts just after the last granted requester and wraps.
    always_comb begin
        cand      = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!grant_any && req_valid_in[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == IdxW'(k)) begin
                grant_data = req_data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer        = en_in & ~arst & grant_any;
    assign pipe_en_out = en_in;

    always_comb begin
        req_ready_out = '0;
        if (xfer) begin
            req_ready_out[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        pipe_data_d  = pipe_data_q;
        pipe_valid_d = pipe_valid_q;
        pipe_idx_d   = pipe_idx_q;
        tag_vld_d    = tag_vld_q;
        tag_idx_d    = tag_idx_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = '0;
        err_d        = err_q;
        if (en_in) begin
            if (xfer) begin
                last_grant_d = grant_idx;
                pipe_data_d  = grant_data;
                pipe_idx_d   = grant_idx;
            end
            pipe_valid_d = grant_any;
            // Tags trail pipe_valid_out so they leave the shift register with pipe_valid_in.
            tag_vld_d[0] = pipe_valid_q;
            tag_idx_d[0] = pipe_idx_q;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_idx_d[i] = tag_idx_q[i-1];
            end
            if (pipe_valid_in) begin
                rsp_data_d = pipe_data_in;
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    rsp_valid_d[k] = (tag_idx_q[LATENCY-1] == IdxW'(k));
                end
            end
            if (pipe_valid_in != tag_vld_q[LATENCY-1]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            last_grant_q <= IdxW'(NUM_REQ - 1);
            pipe_data_q  <= '0;
            pipe_valid_q <= 1'b0;
            pipe_idx_q   <= '0;
            tag_vld_q    <= '0;
            tag_idx_q    <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            pipe_data_q  <= pipe_data_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_idx_q   <= pipe_idx_d;
            tag_vld_q    <= tag_vld_d;
            tag_idx_q    <= tag_idx_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            err_q        <= err_d;
        end
    end

    assign pipe_data_out  = pipe_data_q;
    assign pipe_valid_out = pipe_valid_q;
    assign rsp_data_out   = rsp_data_q;
    assign rsp_valid_out  = rsp_valid_q;
    assign err_out        = err_q;

`ifdef PIPE_RR_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (xfer && (cnt_q[grant_idx] != 16'hFFFF)) begin
            cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Self-checking bench for pipe_rr_arbiter: transaction-level model plus directed literal checks.
// Define PIPE_RR_ARBITER_STATS_EN to also exercise the grant counters.
module tb_pipe_rr_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int LAT = 10;
    localparam logic [NR-1:0] ONE = 1;

    logic                 clk = 1'b0;
    logic                 arst = 1'b1;
    logic                 en_in = 1'b0;
    logic [NR-1:0]        req_valid_in = '0;
    logic [NR*DW-1:0]     req_data_in = '0;
    logic [NR-1:0]        req_ready_out;
    logic [DW-1:0]        pipe_data_out;
    logic                 pipe_valid_out;
    logic                 pipe_en_out;
    logic [DW-1:0]        pipe_data_in;
    logic                 pipe_valid_in;
    logic [DW-1:0]        rsp_data_out;
    logic [NR-1:0]        rsp_valid_out;
    logic                 err_out;
`ifdef PIPE_RR_ARBITER_STATS_EN
    logic [NR*16-1:0]     grant_cnt_out;
`endif

    pipe_rr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .LATENCY    (LAT)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .en_in          (en_in),
        .req_valid_in   (req_valid_in),
        .req_data_in    (req_data_in),
        .req_ready_out  (req_ready_out),
        .pipe_data_out  (pipe_data_out),
        .pipe_valid_out (pipe_valid_out),
        .pipe_en_out    (pipe_en_out),
        .pipe_data_in   (pipe_data_in),
        .pipe_valid_in  (pipe_valid_in),
        .rsp_data_out   (rsp_data_out),
        .rsp_valid_out  (rsp_valid_out),
`ifdef PIPE_RR_ARBITER_STATS_EN
        .grant_cnt_out  (grant_cnt_out),
`endif
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Shared pipeline environment: LAT-stage delay that advances with pipe_en_out.
    logic [LAT-1:0] line_v;
    logic [DW-1:0]  line_d [LAT];
    logic           force_pv = 1'b0;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            line_v <= '0;
            for (int i = 0; i < LAT; i++) line_d[i] <= '0;
        end else if (pipe_en_out) begin
            line_v <= {line_v[LAT-2:0], pipe_valid_out};
            line_d[0] <= pipe_data_out;
            for (int i = 1; i < LAT; i++) line_d[i] <= line_d[i-1];
        end
    end

    assign pipe_valid_in = force_pv | line_v[LAT-1];
    assign pipe_data_in  = line_d[LAT-1];

    // Transaction model: each transfer is owed back 12 enabled edges later.
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } item_t;

    item_t         mq[$];
    int            m_last = NR - 1;
    int            ecnt = 0;
    logic          m_pv = 1'b0;
    logic [DW-1:0] m_pd = '0;
    logic [DW-1:0] m_rd = '0;
    logic [NR-1:0] m_rv = '0;
    logic          m_err = 1'b0;
    bit            chk_rsp = 1'b1;

    always @(negedge clk) begin
        int            g;
        int            c;
        int            fi;
        bit            found;
        logic [NR-1:0] e_rdy;
        if (arst) begin
            chk("rst_ready", req_ready_out, 0);
            chk("rst_pvalid", pipe_valid_out, 0);
            chk("rst_pdata", pipe_data_out, 0);
            chk("rst_rspv", rsp_valid_out, 0);
            chk("rst_rspd", rsp_data_out, 0);
            chk("rst_err", err_out, 0);
            mq.delete();
            m_last = NR - 1;
            m_pv = 1'b0; m_pd = '0; m_rd = '0; m_rv = '0; m_err = 1'b0;
        end else begin
            g = -1;
            if (en_in) begin
                for (int k = 1; k <= NR; k++) begin
                    c = (m_last + k) % NR;
                    if (g < 0 && req_valid_in[c]) g = c;
                end
            end
            e_rdy = (g >= 0) ? (ONE << g) : '0;
            chk("m_ready", req_ready_out, e_rdy);
            chk("m_pen", pipe_en_out, en_in);
            chk("m_pvalid", pipe_valid_out, m_pv);
            if (m_pv) chk("m_pdata", pipe_data_out, m_pd);
            if (chk_rsp) begin
                chk("m_rspv", rsp_valid_out, m_rv);
                chk("m_rspd", rsp_data_out, m_rd);
            end
            chk("m_err", err_out, m_err);
            m_rv = '0;
            if (en_in) begin
                ecnt++;
                found = 1'b0;
                fi = 0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].due == ecnt) begin found = 1'b1; fi = i; end
                end
                if (found) begin
                    m_rv = ONE << mq[fi].idx;
                    m_rd = mq[fi].data;
                    mq.delete(fi);
                end
                if (pipe_valid_in != found) m_err = 1'b1;
                m_pv = (g >= 0);
                if (g >= 0) begin
                    m_pd = req_data_in[g*DW +: DW];
                    mq.push_back('{due: ecnt + LAT + 1, idx: g, data: m_pd});
                    m_last = g;
                end
            end
        end
    end

    function automatic logic [NR*DW-1:0] put(input int i, input logic [DW-1:0] v);
        logic [NR*DW-1:0] r;
        r = '0;
        r[i*DW +: DW] = v;
        return r;
    endfunction

    task automatic drive(input logic en, input logic [NR-1:0] v, input logic [NR*DW-1:0] d);
        @(posedge clk);
        #1;
        en_in = en;
        req_valid_in = v;
        req_data_in = d;
    endtask

    localparam logic [NR*DW-1:0] D_ALL = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    initial begin
        logic [DW-1:0] ed;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;

        // All four requesters streaming: grants rotate 0,1,2,3 and return 12 cycles later.
        for (int j = 0; j < 16; j++) begin
            drive(1'b1, 4'hF, D_ALL);
            @(negedge clk);
            chk("t1_ready", req_ready_out, 4'b0001 << (j % 4));
            if (j >= 12) begin
                chk("t1_rspv", rsp_valid_out, 4'b0001 << ((j - 12) % 4));
                chk("t1_rspd", rsp_data_out, 16'hA000 + (j - 12) % 4);
            end else begin
                chk("t1_rspv_idle", rsp_valid_out, 0);
            end
        end
        repeat (16) drive(1'b1, '0, '0);

        // Single requester: full throughput.
        for (int j = 0; j < 16; j++) begin
            drive(1'b1, 4'b0100, put(2, 16'h1234));
            @(negedge clk);
            chk("t2_ready", req_ready_out, 4'b0100);
            if (j >= 12) begin
                chk("t2_rspv", rsp_valid_out, 4'b0100);
                chk("t2_rspd", rsp_data_out, 16'h1234);
            end else begin
                chk("t2_rspv_idle", rsp_valid_out, 0);
            end
        end
        repeat (16) drive(1'b1, '0, '0);

        // Five-cycle stall right after the first transfer.
        for (int j = 0; j < 31; j++) begin
            drive(!(j >= 1 && j <= 5), (j < 10) ? 4'b0010 : 4'b0000, put(1, 16'(16'h0100 + j)));
            @(negedge clk);
            chk("t3_ready", req_ready_out, (j < 10 && !(j >= 1 && j <= 5)) ? 4'b0010 : 4'b0000);
            if (j >= 1 && j <= 6) begin
                chk("t3_frozen_pv", pipe_valid_out, 1);
                chk("t3_frozen_pd", pipe_data_out, 16'h0100);
            end
            if (j == 17 || (j >= 18 && j <= 21)) begin
                ed = (j == 17) ? 16'h0100 : 16'(16'h0106 + (j - 18));
                chk("t3_rspv", rsp_valid_out, 4'b0010);
                chk("t3_rspd", rsp_data_out, ed);
            end else begin
                chk("t3_rspv_idle", rsp_valid_out, 0);
            end
        end

        // Spurious pipe_valid_in with no tag in flight sets a sticky error.
        chk_rsp = 1'b0;
        @(posedge clk);
        #1 force_pv = 1'b1; en_in = 1'b1; req_valid_in = '0;
        @(negedge clk);
        chk("t4_err_before", err_out, 0);
        @(posedge clk);
        #1 force_pv = 1'b0;
        @(negedge clk);
        chk("t4_err_set", err_out, 1);
        for (int j = 0; j < 6; j++) begin
            drive(j[0], '0, '0);
            @(negedge clk);
            chk("t4_err_sticky", err_out, 1);
        end
        @(posedge clk);
        #1 arst = 1'b1;
        @(negedge clk);
        chk("t4_err_clr", err_out, 0);
        @(posedge clk);
        #1 arst = 1'b0;
        chk_rsp = 1'b1;

        // Reset with six transfers in flight.
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 4'hF, D_ALL);
            @(negedge clk);
            chk("t5_ready", req_ready_out, 4'b0001 << (j % 4));
        end
        @(posedge clk);
        #1 arst = 1'b1;
        @(negedge clk);
        chk("t5_ready_in_rst", req_ready_out, 0);
        @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        chk("t5_first_grant", req_ready_out, 4'b0001);
        for (int j = 1; j < 12; j++) begin
            drive(1'b1, 4'hF, D_ALL);
            @(negedge clk);
            chk("t5_no_stale_rsp", rsp_valid_out, 0);
        end
        drive(1'b1, '0, '0);
        @(negedge clk);
        chk("t5_new_rspv", rsp_valid_out, 4'b0001);
        chk("t5_new_rspd", rsp_data_out, 16'hA000);
        repeat (16) drive(1'b1, '0, '0);

`ifdef PIPE_RR_ARBITER_STATS_EN
        // Counter saturation on requester 1.
        @(posedge clk);
        #1 arst = 1'b1;
        @(posedge clk);
        #1 arst = 1'b0;
        en_in = 1'b1; req_valid_in = 4'b0010; req_data_in = put(1, 16'h5555);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t6_cnt_100", grant_cnt_out[16 +: 16], 100);
        repeat (69900) @(posedge clk);
        #1 req_valid_in = '0;
        @(negedge clk);
        chk("t6_cnt1_sat", grant_cnt_out[16 +: 16], 16'hFFFF);
        chk("t6_cnt0", grant_cnt_out[0 +: 16], 0);
        chk("t6_cnt2", grant_cnt_out[32 +: 16], 0);
        chk("t6_cnt3", grant_cnt_out[48 +: 16], 0);
        repeat (16) drive(1'b1, '0, '0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_rr_arbiter.md
PIPE_RR_ARBITER -- requirements
Module: pipe_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: signed sample width.
REQ-003 SHALL have parameter LATENCY, default 10: fixed latency, in enabled cycles, of the shared pipeline.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port arst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port en_in, input, 1 bit: global advance enable; low stalls the whole block.
REQ-007 SHALL have port req_valid_in, input, NUM_REQ bits: per-requester valid.
REQ-008 SHALL have port req_data_in, input, NUM_REQ*DATA_WIDTH bits: requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ready_out, output, NUM_REQ bits: one-hot grant, or all zero.
REQ-010 SHALL have ports pipe_data_out (DATA_WIDTH bits), pipe_valid_out (1 bit) and pipe_en_out (1 bit), all outputs: drive to the shared pipeline.
REQ-011 SHALL have ports pipe_data_in (DATA_WIDTH bits) and pipe_valid_in (1 bit), both inputs: returned from the shared pipeline.
REQ-012 SHALL have ports rsp_data_out (DATA_WIDTH bits) and rsp_valid_out (NUM_REQ bits, one-hot), both outputs: routed result.
REQ-013 SHALL have port err_out, output, 1 bit: sticky tag/valid mismatch flag.

Function
REQ-014 SHALL raise req_ready_out[i] combinationally only when en_in=1 and req_valid_in[i]=1; a transfer occurs when valid and ready are both high.
REQ-015 SHALL grant round-robin: search starts at last_grant+1, wraps from NUM_REQ-1 to 0, and grants the first valid requester.
REQ-016 SHALL update last_grant only on cycles with a transfer; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-017 SHALL register the granted data and valid into pipe_data_out/pipe_valid_out at the next enabled edge; on an enabled cycle with no grant, pipe_valid_out SHALL be 0.
REQ-018 SHALL drive pipe_en_out = en_in combinationally.
REQ-019 SHALL hold a tag shift register of LATENCY entries (valid + requester index) that advances in lockstep with pipe_en_out and is loaded with the launched grant.
REQ-020 SHALL, on an enabled cycle with pipe_valid_in=1, register pipe_data_in into rsp_data_out and set the rsp_valid_out bit indexed by the tag at the shift-register output. Total latency is LATENCY+2 enabled cycles from transfer to rsp_valid_out.
REQ-021 SHALL drive rsp_valid_out to all zero on any cycle where en_in=0 or no response returns; rsp_data_out holds its last value.
REQ-022 SHALL hold pipe_data_out, pipe_valid_out, the tag register and last_grant unchanged while en_in=0.
REQ-023 SHALL set err_out when pipe_valid_in differs from the output tag valid on an enabled cycle; err_out clears only on reset.
REQ-024 SHALL treat a single active requester as granted every enabled cycle, giving 100% throughput.

Reset
REQ-025 SHALL, while arst=1, clear pipe_data_out, pipe_valid_out, rsp_data_out, rsp_valid_out, err_out and all tag entries; last_grant SHALL be NUM_REQ-1.
REQ-026 SHALL hold req_ready_out at 0 while arst=1; an assertion of arst mid-stream discards all in-flight tags.

Configuration
REQ-027 SHALL, with macro PIPE_RR_ARBITER_STATS_EN defined, add output grant_cnt_out (NUM_REQ*16 bits): per-requester 16-bit transfer counters that saturate at 65535 and are cleared by reset.
REQ-028 SHALL, without PIPE_RR_ARBITER_STATS_EN, omit the grant_cnt_out port and its counters entirely; all other behaviour is identical.

Verification
REQ-029 SHALL cover: all 4 requesters valid continuously with en_in=1 -> grants 0,1,2,3,0,...; each rsp_valid_out bit pulses at transfer+12.
REQ-030 SHALL cover: only requester 2 valid with data 0x1234 -> ready every cycle; rsp_valid_out=4'b0100 with rsp_data_out=0x1234 at transfer+12.
REQ-031 SHALL cover: en_in low for 5 cycles mid-stream -> no ready, outputs frozen, responses delayed by exactly 5 cycles, no data lost.
REQ-032 SHALL cover: pipe_valid_in forced to 1 with an empty tag -> err_out=1 next edge, staying 1 until arst.
REQ-033 SHALL cover: arst pulsed with 6 transfers in flight -> no rsp_valid_out afterwards; first grant after reset goes to requester 0.
REQ-034 SHALL cover, with PIPE_RR_ARBITER_STATS_EN: 70000 transfers by requester 1 -> its counter reads 65535; the other counters read 0.
